// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: 100 Hz time base, debounced buttons, IDLE/RUN/PAUSE/LAP FSM
// and a BCD mm:ss.cc counter with a lap hold register feeding a registered display.
module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic       clk_50MHz,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    output logic       tick_100Hz,
    output logic [7:0] cs_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       lap_active
);

    localparam int unsigned PresW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StLap} state_e;

    logic [PresW-1:0] presc_q;
    logic             tick;
    // Button vectors are packed {clear, lap, start}
    logic [2:0]       sync1_q, sync2_q, samp_q, press;
    logic             start_p, lap_p, clear_p;
    state_e           state_q, state_d;
    logic             do_count, do_latch, do_clear;
    // Counter layout: [23:16] minutes, [15:8] seconds, [7:0] centiseconds, all BCD
    logic [23:0]      live_q, live_inc, hold_q, disp_q;
    logic             c0, c1, c2, c3, c4, c5;

    // Prescaler producing the one-cycle time-base pulse
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    assign tick       = (presc_q == PresLast);
    assign tick_100Hz = tick;

    // Two-flop synchronizers plus tick-rate resampling for debounce; samp resets high so a
    // button held across reset release needs a release before it can press again
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            samp_q  <= 3'b111;
        end else begin
            sync1_q <= {btn_clear, btn_lap, btn_start};
            sync2_q <= sync1_q;
            if (tick) begin
                samp_q <= sync2_q;
            end
        end
    end

    assign press   = {3{tick}} & sync2_q & ~samp_q;
    assign start_p = press[0];
    assign lap_p   = press[1] & ~press[0];
    assign clear_p = press[2] & ~press[1] & ~press[0];

    // FSM state register
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; presses only exist on tick cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_p) state_d = StRun;
            StRun:   if (start_p) state_d = StPause;
                     else if (lap_p) state_d = StLap;
            StLap:   if (start_p) state_d = StPause;
                     else if (lap_p) state_d = StRun;
            StPause: if (start_p) state_d = StRun;
                     else if (clear_p) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath controls, decoded from the pre-update state
    always_comb begin
        running    = (state_q == StRun) || (state_q == StLap);
        lap_active = (state_q == StLap);
        do_count   = tick && running;
        do_latch   = (state_q == StRun) && lap_p;
        do_clear   = (state_q == StPause) && clear_p;
    end

    // BCD increment with carries cs->sec->min and wrap at 59:59.99
    always_comb begin
        c0 = (live_q[3:0] == 4'd9);
        c1 = c0 && (live_q[7:4] == 4'd9);
        c2 = c1 && (live_q[11:8] == 4'd9);
        c3 = c2 && (live_q[15:12] == 4'd5);
        c4 = c3 && (live_q[19:16] == 4'd9);
        c5 = c4 && (live_q[23:20] == 4'd5);
        live_inc        = live_q;
        live_inc[3:0]   = c0 ? 4'd0 : live_q[3:0] + 4'd1;
        if (c0) live_inc[7:4]   = c1 ? 4'd0 : live_q[7:4] + 4'd1;
        if (c1) live_inc[11:8]  = c2 ? 4'd0 : live_q[11:8] + 4'd1;
        if (c2) live_inc[15:12] = c3 ? 4'd0 : live_q[15:12] + 4'd1;
        if (c3) live_inc[19:16] = c4 ? 4'd0 : live_q[19:16] + 4'd1;
        if (c4) live_inc[23:20] = c5 ? 4'd0 : live_q[23:20] + 4'd1;
    end

    // Live counter, lap hold register and registered display
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            live_q <= '0;
            hold_q <= '0;
            disp_q <= '0;
        end else begin
            if (do_clear) begin
                live_q <= '0;
            end else if (do_count) begin
                live_q <= live_inc;
            end
            if (do_latch) begin
                hold_q <= live_q;
            end
            disp_q <= (state_q == StLap) ? hold_q : live_q;
        end
    end

    assign cs_bcd  = disp_q[7:0];
    assign sec_bcd = disp_q[15:8];
    assign min_bcd = disp_q[23:16];

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV = 4.
module tb_stopwatch_ctrl;

    logic       clk_50MHz = 1'b0;
    logic       reset;
    logic       btn_start, btn_lap, btn_clear;
    logic       tick_100Hz;
    logic [7:0] cs_bcd, sec_bcd, min_bcd;
    logic       running, lap_active;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(.TICK_DIV(4)) dut (
        .clk_50MHz  (clk_50MHz),
        .reset      (reset),
        .btn_start  (btn_start),
        .btn_lap    (btn_lap),
        .btn_clear  (btn_clear),
        .tick_100Hz (tick_100Hz),
        .cs_bcd     (cs_bcd),
        .sec_bcd    (sec_bcd),
        .min_bcd    (min_bcd),
        .running    (running),
        .lap_active (lap_active)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    // Returns at the falling edge inside the next tick cycle (the coming rising edge is a tick)
    task automatic wait_tick();
        int n;
        n = 0;
        @(negedge clk_50MHz);
        while (tick_100Hz !== 1'b1 && n < 16) begin
            @(negedge clk_50MHz);
            n++;
        end
        if (tick_100Hz !== 1'b1) begin
            errors++;
            $display("FAIL wait_tick: tick_100Hz=%b, required 1 within 16 cycles", tick_100Hz);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    // b = {clear, lap, start}; the press registers on the second tick edge after the call
    task automatic press(input logic [2:0] b);
        wait_tick();
        {btn_clear, btn_lap, btn_start} = b;
        wait_tick();
        wait_tick();
        {btn_clear, btn_lap, btn_start} = 3'b000;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        {btn_clear, btn_lap, btn_start} = 3'b000;
        #35;
        checks++;
        if ({cs_bcd, sec_bcd, min_bcd} !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0 ||
            tick_100Hz !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %h %h %h run=%b lap=%b tick=%b, required all 0",
                     min_bcd, sec_bcd, cs_bcd, running, lap_active, tick_100Hz);
        end
        @(negedge clk_50MHz);
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            #1;
            checks++;
            if (tick_100Hz !== ((i % 4) == 0)) begin
                errors++;
                $display("FAIL tick_cycle%0d: got %b, required %b", i, tick_100Hz, (i % 4) == 0);
            end
            @(negedge clk_50MHz);
        end
    endtask

    task automatic test_idle_ignore();
        press(3'b010);
        checks++;
        if (lap_active !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL idle_lap: run=%b lap=%b, required 0 0", running, lap_active);
        end
        press(3'b100);
        wait_ticks(2);
        checks++;
        if (running !== 1'b0 || {min_bcd, sec_bcd, cs_bcd} !== 24'h0) begin
            errors++;
            $display("FAIL idle_clear: run=%b time=%h:%h.%h, required 0 00:00.00",
                     running, min_bcd, sec_bcd, cs_bcd);
        end
    endtask

    task automatic test_start_pause();
        press(3'b001);
        checks++;
        if (running !== 1'b1 || {min_bcd, sec_bcd, cs_bcd} !== 24'h0) begin
            errors++;
            $display("FAIL start_entry: run=%b time=%h:%h.%h, required 1 00:00.00",
                     running, min_bcd, sec_bcd, cs_bcd);
        end
        wait_ticks(147);
        press(3'b001);
        checks++;
        if (running !== 1'b0) begin
            errors++;
            $display("FAIL pause_running: got %b, required 0", running);
        end
        checks++;
        if ({min_bcd, sec_bcd, cs_bcd} !== 24'h000150) begin
            errors++;
            $display("FAIL pause_time: got %h:%h.%h, required 00:01.50", min_bcd, sec_bcd, cs_bcd);
        end
        press(3'b010);
        wait_ticks(3);
        checks++;
        if (lap_active !== 1'b0 || running !== 1'b0 || {min_bcd, sec_bcd, cs_bcd} !== 24'h000150)
        begin
            errors++;
            $display("FAIL pause_lap_ignored: run=%b lap=%b time=%h:%h.%h, required 0 0 00:01.50",
                     running, lap_active, min_bcd, sec_bcd, cs_bcd);
        end
    endtask

    task automatic test_simultaneous();
        press(3'b101);
        checks++;
        if (running !== 1'b1 || lap_active !== 1'b0) begin
            errors++;
            $display("FAIL simul_state: run=%b lap=%b, required 1 0", running, lap_active);
        end
        checks++;
        if ({min_bcd, sec_bcd, cs_bcd} !== 24'h000150) begin
            errors++;
            $display("FAIL simul_noclear: got %h:%h.%h, required 00:01.50",
                     min_bcd, sec_bcd, cs_bcd);
        end
    endtask

    task automatic test_lap();
        wait_ticks(48);
        press(3'b010);
        checks++;
        if (lap_active !== 1'b1 || running !== 1'b1 || {min_bcd, sec_bcd, cs_bcd} !== 24'h000200)
        begin
            errors++;
            $display("FAIL lap_enter: run=%b lap=%b time=%h:%h.%h, required 1 1 00:02.00",
                     running, lap_active, min_bcd, sec_bcd, cs_bcd);
        end
        wait_ticks(96);
        checks++;
        if ({min_bcd, sec_bcd, cs_bcd} !== 24'h000200) begin
            errors++;
            $display("FAIL lap_frozen: got %h:%h.%h, required 00:02.00", min_bcd, sec_bcd, cs_bcd);
        end
        press(3'b010);
        checks++;
        if (lap_active !== 1'b0 || running !== 1'b1 || {min_bcd, sec_bcd, cs_bcd} !== 24'h000300)
        begin
            errors++;
            $display("FAIL lap_exit: run=%b lap=%b time=%h:%h.%h, required 1 0 00:03.00",
                     running, lap_active, min_bcd, sec_bcd, cs_bcd);
        end
    endtask

    task automatic test_wrap();
        @(posedge clk_50MHz);
        #1;
        force dut.live_q = 24'h595999;
        #1;
        release dut.live_q;
        wait_tick();
        checks++;
        if ({min_bcd, sec_bcd, cs_bcd} !== 24'h595999) begin
            errors++;
            $display("FAIL wrap_pre: got %h:%h.%h, required 59:59.99", min_bcd, sec_bcd, cs_bcd);
        end
        wait_tick();
        checks++;
        if ({min_bcd, sec_bcd, cs_bcd} !== 24'h000000 || running !== 1'b1) begin
            errors++;
            $display("FAIL wrap_post: run=%b time=%h:%h.%h, required 1 00:00.00",
                     running, min_bcd, sec_bcd, cs_bcd);
        end
    endtask

    task automatic test_reset_mid();
        btn_start = 1'b1;
        reset = 1'b0;
        #1;
        checks++;
        if ({min_bcd, sec_bcd, cs_bcd} !== 24'h0 || running !== 1'b0 || lap_active !== 1'b0 ||
            tick_100Hz !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h %h %h run=%b lap=%b tick=%b, required all 0",
                     min_bcd, sec_bcd, cs_bcd, running, lap_active, tick_100Hz);
        end
        repeat (3) @(negedge clk_50MHz);
        reset = 1'b1;
        wait_ticks(4);
        checks++;
        if (running !== 1'b0 || {min_bcd, sec_bcd, cs_bcd} !== 24'h0) begin
            errors++;
            $display("FAIL held_start_ignored: run=%b time=%h:%h.%h, required 0 00:00.00",
                     running, min_bcd, sec_bcd, cs_bcd);
        end
        btn_start = 1'b0;
        wait_ticks(2);
        press(3'b001);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL repress_start: got %b, required 1", running);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_start_pause();
        test_simultaneous();
        test_lap();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
